// File: rtl/rr_mux_arb_pkg.sv
// Shared constants for the round-robin / fixed-priority registered mux:
// channel-index width helper, arbitration mode encodings and FSM states.
package rr_mux_arb_pkg;

    localparam int MODE_PRIO = 0;
    localparam int MODE_RR   = 1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Channel index width; a single channel still needs a 1-bit index.
    function automatic int cw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Combinational arbiter: picks the first requester at/after ptr (round robin)
// or the lowest requester (fixed priority). Returns one-hot grant and index.
module rr_arb_core
    import rr_mux_arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = cw_of(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    input  logic           rr_mode,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  idx
);

    always_comb begin
        int   c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        // ptr is always < NCH, so the rotation is a true modulo-NCH walk
        for (int k = 0; k < NCH; k++) begin
            c = rr_mode ? (int'(ptr) + k) % NCH : k;
            if (!found && req[c]) begin
                gnt[c] = 1'b1;
                idx    = CW'(c);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel registered mux with round-robin or fixed-priority arbitration,
// output backpressure and multi-beat packet locking.
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NCH   = 4,
    parameter  int MODE  = MODE_RR,
    localparam int CW    = cw_of(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_last,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [CW-1:0]        out_ch,
    input  logic                 out_ready
);

    state_t           state;
    logic [CW-1:0]    ptr, lock_ch, arb_idx, cur_ch, nxt_ptr;
    logic [NCH-1:0]   arb_gnt, grant;
    logic             load, xfer, cur_last;
    logic [WIDTH-1:0] cur_data;

    rr_arb_core #(.NCH(NCH), .CW(CW)) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .rr_mode (MODE == MODE_RR),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    always_comb begin
        grant  = '0;
        cur_ch = arb_idx;
        // A locked packet owns the output even while its source bubbles
        if (state == ST_LOCKED) begin
            grant[lock_ch] = 1'b1;
            cur_ch         = lock_ch;
        end else begin
            grant = arb_gnt;
        end
        load     = !out_valid || out_ready;
        in_ready = (rst_n && load) ? grant : '0;
        xfer     = |(in_ready & in_valid);
        cur_last = in_last[cur_ch];
        cur_data = in_data[cur_ch*WIDTH +: WIDTH];
        nxt_ptr  = (cur_ch == CW'(NCH - 1)) ? '0 : cur_ch + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ARB;
            ptr       <= '0;
            lock_ch   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= cur_data;
                out_last <= cur_last;
                out_ch   <= cur_ch;
                if (cur_last) begin
                    state <= ST_ARB;
                    if (MODE == MODE_RR) ptr <= nxt_ptr;
                end else begin
                    state   <= ST_LOCKED;
                    lock_ch <= cur_ch;
                end
            end
        end
    end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with arbitration.
- Selects among several valid/ready data sources and drives one output register.
- Used in the calculator datapath to merge keypad operands, ALU results and memory readback onto the shared display/operand bus.
- Adds round-robin or fixed-priority selection, backpressure and multi-beat packet locking on top of a plain static 2:1 select.

Parameters:
- WIDTH, 16, data width of each channel and of the output.
- NCH, 4, number of input channels (≥1).
- MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round robin.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel beat valid.
- in_last  input  NCH  per-channel last-beat-of-packet flag.
- in_ready  output  NCH  per-channel accept, combinational.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_last  output  1  registered copy of the accepted in_last.
- out_ch  output  CW  registered index of the source channel; CW = max(1, clog2(NCH)).
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_last=0, out_ch=0.
  - RR pointer=0, state=ARB.
  - in_ready=0 while rst_n is low.
- Load condition: load = (!out_valid || out_ready).
- Transfer on channel i: load && grant[i] && in_valid[i]. in_ready[i] = load && grant[i]. At most one in_ready bit is high.
- Latency: a beat accepted on edge k appears on out_* after edge k. Full throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, all out_* hold stable and all in_ready=0.
- Output register update on each edge:
  - Transfer: load new data, last and channel; out_valid=1.
  - load without transfer: out_valid=0. out_data, out_last and out_ch hold their values (don't-care).
- FSM state ARB:
  - grant = winner among in_valid.
  - MODE=1: the first valid channel at or after the RR pointer, wrapping at NCH-1→0.
  - MODE=0: the lowest valid index.
  - On transfer with in_last=1: stay in ARB. If MODE=1, pointer = winner+1 mod NCH.
  - On transfer with in_last=0: go to LOCKED, lock_ch = winner.
- FSM state LOCKED:
  - grant is one-hot on lock_ch regardless of the other valids; other channels see in_ready=0.
  - If lock_ch drops in_valid: stay LOCKED and insert bubbles; no other channel may be granted.
  - On transfer with in_last=1: return to ARB. If MODE=1, pointer = lock_ch+1 mod NCH.
- Simultaneous events: stall and arbitration do not interact; the grant is computed every cycle but only takes effect when load=1. The pointer advances only on a packet-ending transfer.
- Edge cases:
  - NCH=1: the pointer stays 0 and out_ch=0.
  - No valid inputs in ARB: no transfer; out_valid drops after the current beat is consumed.
- Reset mid-packet: the lock is abandoned and any beat held in the output register is discarded. The state returns to ARB with pointer 0.
- Width rules: no arithmetic on data. Pointer arithmetic is modulo NCH, not modulo 2^CW.

Decomposition:
- Shared package: CW width function (clog2 with minimum 1), MODE encodings (MODE_PRIO=0, MODE_RR=1), FSM state constants (ST_ARB, ST_LOCKED).
- One sub-module, rr_arb_core: purely combinational.
  - Inputs: request vector, pointer, mode.
  - Outputs: one-hot grant and encoded index.
  - Instantiated once; the locking override is applied in the parent.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111 → in_ready=0, out_valid=0, out_data=0x0000. Release → first transfer is from ch0.
- Round robin (WIDTH=16, NCH=4, MODE=1):
  - Stimulus: all channels valid, in_last=1, data 0x1000+i, out_ready=1.
  - Response: out_ch sequence 0,1,2,3,0 on consecutive cycles; out_data 0x1000..0x1003,0x1000. First out_valid one cycle after the first transfer.
- Backpressure: out holds 0xABCD from ch2, out_ready=0 for 3 cycles → out_data, out_ch=2 and out_valid stay stable, in_ready=0000. With out_ready=1 the next beat (ch3) appears on the following edge.
- Packet lock:
  - Stimulus: ch2 sends 0x2001,0x2002,0x2003 with last on the third; ch1 valid throughout. Insert a 1-cycle in_valid gap on ch2 after the second beat.
  - Response: out_ch=2,2,(bubble),2. ch1 in_ready=0 until ch2's last beat is accepted, then ch1 is granted next.
- Fixed priority (MODE=0): ch1 and ch3 continuously valid with last=1 → every output beat has out_ch=1; ch3 is never granted.
- Reset mid-packet: assert rst_n=0 after ch0's first beat (last=0) while ch3 is valid → out_valid=0 immediately. After release, ch0 is not locked; with only ch3 valid, out_ch=3 on the first transfer.
